// File: rtl/i2s_led_pkg.sv
// Shared definitions for the I2S LED tile stream blocks: FSM state codes,
// header field layout and header width derivation.
package i2s_led_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_HDR  = 1'b0;
  localparam state_t ST_DATA = 1'b1;

  localparam int BRI_W = 8;

  // Header layout, MSB first: num_x_m1, num_y_m1, brightness, row.
  function automatic int hdr_w_f(input int addr_w, input int row_w);
    return 2 * addr_w + BRI_W + row_w;
  endfunction

  function automatic int bri_lsb_f(input int row_w);
    return row_w;
  endfunction

  function automatic int ny_lsb_f(input int row_w);
    return row_w + BRI_W;
  endfunction

  function automatic int nx_lsb_f(input int addr_w, input int row_w);
    return row_w + BRI_W + addr_w;
  endfunction

endpackage

// File: rtl/i2s_oe_timer.sv
// Loadable 8-bit down-counter; the active-low output enable is asserted
// while the count is nonzero. A load while counting restarts the count.
module i2s_oe_timer
  import i2s_led_pkg::*;
(
  input  logic             i2s_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BRI_W-1:0] load_val,
  output logic             led_oe
);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       oe_r;

  // Next count: a load wins over the decrement; the count rests at zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = load_val;
    end else if (cnt_r != 8'd0) begin
      cnt_nxt_s = cnt_r - 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register and registered enable, so led_oe drops with the load edge.
  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
      oe_r  <= 1'b1;
    end else begin
      cnt_r <= cnt_nxt_s;
      oe_r  <= (cnt_nxt_s == 8'd0);
    end
  end

  assign led_oe = oe_r;

endmodule

// File: rtl/i2s_tile_mask.sv
// Extracts this tile's bit segments from a headered I2S frame, forwards them
// to the LED chain with a gated clock, and latches/times the panel output.
module i2s_tile_mask
  import i2s_led_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int ROW_W     = 6,
  parameter int LANES     = 1,
  parameter int TILE_BITS = 4,
  parameter int TILE_SEGS = 4,
  parameter int CNT_W     = 16
) (
  input  logic              i2s_clk,
  input  logic              rst_n,
  input  logic              i2s_ws,
  input  logic [LANES-1:0]  i2s_data,
  input  logic [ADDR_W-1:0] addr_x,
  input  logic [ADDR_W-1:0] addr_y,
  output logic [ROW_W-1:0]  row_num,
  output logic [LANES-1:0]  led_data,
  output logic              led_clk,
  output logic              led_lat,
  output logic              led_oe,
  output logic              frame_err
);

  localparam int HDR_W  = hdr_w_f(ADDR_W, ROW_W);
  localparam int NX_LSB = nx_lsb_f(ADDR_W, ROW_W);
  localparam int NY_LSB = ny_lsb_f(ROW_W);
  localparam int BR_LSB = bri_lsb_f(ROW_W);
  localparam int SEG_W  = $clog2(TILE_SEGS + 1);
  localparam int OFF_W  = $clog2(TILE_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SEG_W-1:0] SEG_ONE  = {{(SEG_W-1){1'b0}}, 1'b1};
  localparam logic [OFF_W-1:0] OFF_ONE  = {{(OFF_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [HDR_W-2:0]   hdr_sr_r;
  logic [CNT_W-1:0]   total_r;
  logic [CNT_W-1:0]   seg_base_r;
  logic [CNT_W-1:0]   stride_r;
  logic [SEG_W-1:0]   seg_cnt_r;
  logic [OFF_W-1:0]   off_cnt_r;
  logic               in_range_r;
  logic [BRI_W-1:0]   bri_r;
  logic [ROW_W-1:0]   row_hdr_r;
  logic [ROW_W-1:0]   row_num_r;
  logic [LANES-1:0]   led_data_r;
  logic               led_clk_en_r;
  logic               led_lat_r;
  logic               frame_err_r;

  // Header as it stands including the bit being sampled now (lane 0 only).
  logic [HDR_W-1:0]   hdr_full_s;
  logic [ADDR_W-1:0]  nx_s;
  logic [ADDR_W-1:0]  ny_s;
  logic [CNT_W-1:0]   nx1_s;
  logic [CNT_W-1:0]   ny1_s;
  logic [CNT_W-1:0]   total_s;
  logic [CNT_W-1:0]   first_s;
  logic [CNT_W-1:0]   stride_s;
  logic               in_range_s;

  assign hdr_full_s = {hdr_sr_r, i2s_data[0]};
  assign nx_s       = hdr_full_s[NX_LSB +: ADDR_W];
  assign ny_s       = hdr_full_s[NY_LSB +: ADDR_W];
  assign nx1_s      = CNT_W'(nx_s) + CNT_ONE;
  assign ny1_s      = CNT_W'(ny_s) + CNT_ONE;
  assign total_s    = CNT_W'(TILE_BITS * TILE_SEGS) * nx1_s * ny1_s;
  assign first_s    = CNT_W'(TILE_BITS) *
                      (CNT_W'(addr_y) * nx1_s * CNT_W'(TILE_SEGS) + CNT_W'(addr_x));
  assign stride_s   = CNT_W'(TILE_BITS) * nx1_s;
  assign in_range_s = (addr_x <= nx_s) && (addr_y <= ny_s);

  logic err_s;
  logic hdr_take_s;
  logic hdr_last_s;
  logic data_last_s;
  logic sel_s;

  // Per-bit decode: misplaced ws, header progress, last data bit, tile select.
  always_comb begin
    err_s       = 1'b0;
    hdr_take_s  = 1'b0;
    hdr_last_s  = 1'b0;
    data_last_s = 1'b0;
    sel_s       = 1'b0;
    case (state_r)
      ST_HDR: begin
        err_s      = i2s_ws && (bit_cnt_r != CNT_ZERO);
        // Bit 0 is only accepted with ws, so an idle line never starts a frame.
        hdr_take_s = i2s_ws || (bit_cnt_r != CNT_ZERO);
        hdr_last_s = hdr_take_s && !err_s && (bit_cnt_r == CNT_W'(HDR_W - 1));
      end
      ST_DATA: begin
        err_s       = i2s_ws;
        data_last_s = !i2s_ws && (bit_cnt_r == total_r - CNT_ONE);
        // Segments are consumed in order, so one compare against the running
        // segment base suffices: bits before it are skipped, bits from it on
        // are taken until TILE_BITS have gone by.
        sel_s       = !i2s_ws && in_range_r && (seg_cnt_r < SEG_W'(TILE_SEGS)) &&
                      (bit_cnt_r >= seg_base_r);
      end
      default: begin
        err_s = 1'b0;
      end
    endcase
  end

  // Frame FSM, bit counter, header capture and segment walker.
  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HDR;
      bit_cnt_r  <= CNT_ZERO;
      hdr_sr_r   <= {(HDR_W-1){1'b0}};
      total_r    <= CNT_ZERO;
      seg_base_r <= CNT_ZERO;
      stride_r   <= CNT_ZERO;
      seg_cnt_r  <= {SEG_W{1'b0}};
      off_cnt_r  <= {OFF_W{1'b0}};
      in_range_r <= 1'b0;
      bri_r      <= {BRI_W{1'b0}};
      row_hdr_r  <= {ROW_W{1'b0}};
    end else begin
      case (state_r)
        ST_HDR: begin
          if (err_s) begin
            hdr_sr_r  <= {hdr_sr_r[HDR_W-3:0], i2s_data[0]};
            bit_cnt_r <= CNT_ONE;
          end else if (hdr_last_s) begin
            total_r    <= total_s;
            seg_base_r <= first_s;
            stride_r   <= stride_s;
            in_range_r <= in_range_s;
            bri_r      <= hdr_full_s[BR_LSB +: BRI_W];
            row_hdr_r  <= hdr_full_s[ROW_W-1:0];
            seg_cnt_r  <= {SEG_W{1'b0}};
            off_cnt_r  <= {OFF_W{1'b0}};
            bit_cnt_r  <= CNT_ZERO;
            state_r    <= ST_DATA;
          end else if (hdr_take_s) begin
            hdr_sr_r  <= {hdr_sr_r[HDR_W-3:0], i2s_data[0]};
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (err_s) begin
            // The offending bit is the first header bit of a new frame.
            hdr_sr_r  <= {hdr_sr_r[HDR_W-3:0], i2s_data[0]};
            bit_cnt_r <= CNT_ONE;
            state_r   <= ST_HDR;
          end else if (data_last_s) begin
            bit_cnt_r <= CNT_ZERO;
            state_r   <= ST_HDR;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
          if (sel_s) begin
            if (off_cnt_r == OFF_W'(TILE_BITS - 1)) begin
              off_cnt_r  <= {OFF_W{1'b0}};
              seg_base_r <= seg_base_r + stride_r;
              seg_cnt_r  <= seg_cnt_r + SEG_ONE;
            end else begin
              off_cnt_r <= off_cnt_r + OFF_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_HDR;
          bit_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Registered outputs: LED data/clock enable, latch strobe, row, error pulse.
  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      led_data_r   <= {LANES{1'b0}};
      led_clk_en_r <= 1'b0;
      led_lat_r    <= 1'b0;
      row_num_r    <= {ROW_W{1'b0}};
      frame_err_r  <= 1'b0;
    end else begin
      led_clk_en_r <= sel_s;
      led_lat_r    <= data_last_s;
      frame_err_r  <= err_s;
      if (sel_s) begin
        led_data_r <= i2s_data;
      end
      if (data_last_s) begin
        row_num_r <= row_hdr_r;
      end
    end
  end

  i2s_oe_timer u_oe_timer (
    .i2s_clk  (i2s_clk),
    .rst_n    (rst_n),
    .load     (data_last_s),
    .load_val (bri_r),
    .led_oe   (led_oe)
  );

  // Enable only changes just after the rising edge, so the gated clock
  // pulses cleanly in the low phase of the sampling cycle.
  assign led_clk   = ~i2s_clk & led_clk_en_r;
  assign led_data  = led_data_r;
  assign led_lat   = led_lat_r;
  assign row_num   = row_num_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_i2s_tile_mask.sv
// Scoreboard bench for i2s_tile_mask: stimulus pushes expected LED bits,
// latched rows, OE low lengths and error events; monitors pop and compare.
module tb_i2s_tile_mask;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  // default-parameter instance
  logic       ws0 = 1'b0;
  logic [0:0] d0 = 1'b0;
  logic [3:0] ax0 = 4'd1, ay0 = 4'd0;
  logic [5:0] row0;
  logic [0:0] ld0;
  logic       lclk0, lat0, oe0, err0;
  // 3-lane, 8-bit tile, 8-segment instance
  logic       ws1 = 1'b0;
  logic [2:0] d1 = 3'd0;
  logic [3:0] ax1 = 4'd3, ay1 = 4'd3;
  logic [5:0] row1;
  logic [2:0] ld1;
  logic       lclk1, lat1, oe1, err1;

  i2s_tile_mask u0 (
    .i2s_clk(clk), .rst_n(rst_n), .i2s_ws(ws0), .i2s_data(d0),
    .addr_x(ax0), .addr_y(ay0), .row_num(row0), .led_data(ld0),
    .led_clk(lclk0), .led_lat(lat0), .led_oe(oe0), .frame_err(err0)
  );

  i2s_tile_mask #(.LANES(3), .TILE_BITS(8), .TILE_SEGS(8)) u1 (
    .i2s_clk(clk), .rst_n(rst_n), .i2s_ws(ws1), .i2s_data(d1),
    .addr_x(ax1), .addr_y(ay1), .row_num(row1), .led_data(ld1),
    .led_clk(lclk1), .led_lat(lat1), .led_oe(oe1), .frame_err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] q_data0[$];
  logic [2:0] q_data1[$];
  int q_row0[$], q_row1[$], q_oe0[$], q_err0[$];
  int pulses0 = 0, pulses1 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for u0: sampled mid low phase, away from the rising edge.
  initial begin : mon0
    int run;
    run = 0;
    forever begin
      @(negedge clk); #1;
      if (lclk0) begin
        pulses0++;
        if (q_data0.size() == 0) check("u0 unexpected led_clk", lclk0, 0);
        else check("u0 led_data", ld0, q_data0.pop_front());
      end
      if (lat0) begin
        if (q_row0.size() == 0) check("u0 unexpected led_lat", lat0, 0);
        else check("u0 row_num at latch", row0, q_row0.pop_front());
      end
      if (err0) begin
        if (q_err0.size() == 0) check("u0 unexpected frame_err", err0, 0);
        else check("u0 row_num kept at frame_err", row0, q_err0.pop_front());
      end
      if (!oe0) run++;
      else if (run != 0) begin
        if (q_oe0.size() == 0) check("u0 unexpected oe low", run, 0);
        else check("u0 oe low cycles", run, q_oe0.pop_front());
        run = 0;
      end
    end
  end

  // Monitor for u1: per-lane data at each gated clock pulse and latched row.
  initial begin : mon1
    forever begin
      @(negedge clk); #1;
      if (lclk1) begin
        pulses1++;
        if (q_data1.size() == 0) check("u1 unexpected led_clk", lclk1, 0);
        else check("u1 led_data", ld1, q_data1.pop_front());
      end
      if (lat1) begin
        if (q_row1.size() == 0) check("u1 unexpected led_lat", lat1, 0);
        else check("u1 row_num at latch", row1, q_row1.pop_front());
      end
      if (err1) check("u1 unexpected frame_err", err1, 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int u, input logic ws, input logic [2:0] d);
    @(negedge clk);
    if (u == 0) begin ws0 = ws; d0 = d[0]; end
    else begin ws1 = ws; d1 = d; end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) drive(u, 1'b0, 3'd0);
  endtask

  task automatic send_hdr(input int u, input int nx, input int ny, input int bri, input int row);
    logic [21:0] h;
    h = {nx[3:0], ny[3:0], bri[7:0], row[5:0]};
    for (int i = 21; i >= 0; i--) drive(u, (i == 21), {2'b00, h[i]});
  endtask

  // Drives nbits data bits; first/stride/tbits/segs are hand-derived values.
  task automatic send_data(input int u, input int nbits, input int first, input int stride,
                           input int tbits, input int segs, input bit in_range);
    logic [2:0] v;
    bit sel;
    for (int d = 0; d < nbits; d++) begin
      v = 3'($urandom);
      sel = 1'b0;
      if (in_range)
        for (int s = 0; s < segs; s++)
          if (d >= first + s * stride && d < first + s * stride + tbits) sel = 1'b1;
      if (sel) begin
        if (u == 0) q_data0.push_back(v[0]);
        else q_data1.push_back(v);
      end
      drive(u, 1'b0, v);
    end
  endtask

  // Full default-instance frame with nx=1, ny=0 (32 data bits, stride 8).
  task automatic frame0(input int bri, input int row, input int first, input bit in_range,
                        input int exp_oe);
    send_hdr(0, 1, 0, bri, row);
    send_data(0, 32, first, 8, 4, 4, in_range);
    q_row0.push_back(row);
    if (exp_oe > 0) q_oe0.push_back(exp_oe);
  endtask

  initial begin : stim
    #1 rst_n = 1'b0;
    #2;
    check("reset row_num", row0, 0);
    check("reset led_data", ld0, 0);
    check("reset led_clk", lclk0, 0);
    check("reset led_lat", lat0, 0);
    check("reset led_oe", oe0, 1);
    check("reset frame_err", err0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2);

    // addr (1,0): segments at 4-7, 12-15, 20-23, 28-31, OE for 3 cycles
    pulses0 = 0;
    frame0(3, 5, 4, 1'b1, 3);
    idle(0, 2);
    check("u0 pulses addr(1,0)", pulses0, 16);

    // addr (2,0) is beyond nx=1: no pulses, latch and row still update
    ax0 = 4'd2;
    pulses0 = 0;
    frame0(3, 9, 8, 1'b0, 3);
    idle(0, 2);
    check("u0 pulses addr(2,0)", pulses0, 0);
    ax0 = 4'd1;
    idle(0, 4);

    // ws at d=10: error, no latch, row stays 9, the ws bit starts a new header
    pulses0 = 0;
    send_hdr(0, 1, 0, 3, 7);
    send_data(0, 10, 4, 8, 4, 4, 1'b1);
    q_err0.push_back(9);
    frame0(3, 11, 4, 1'b1, 3);
    idle(0, 2);
    check("u0 pulses aborted+new frame", pulses0, 20);
    idle(0, 4);

    // brightness 0 keeps OE high; 200 is reloaded to 3 by a back-to-back
    // latch 54 cycles later, giving one low run of 54+3 cycles
    frame0(0, 12, 4, 1'b1, -1);
    frame0(200, 13, 4, 1'b1, -1);
    frame0(3, 14, 4, 1'b1, 57);
    idle(0, 8);
    check("u0 row_num after reload frames", row0, 14);

    // reset while d=7 is on the line
    send_hdr(0, 1, 0, 3, 15);
    send_data(0, 7, 4, 8, 4, 4, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe reset row_num", row0, 0);
    check("midframe reset led_data", ld0, 0);
    check("midframe reset led_clk", lclk0, 0);
    check("midframe reset led_lat", lat0, 0);
    check("midframe reset led_oe", oe0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 3);
    pulses0 = 0;
    frame0(3, 16, 4, 1'b1, 3);
    idle(0, 6);
    check("u0 pulses after reset", pulses0, 16);

    // 3 lanes, 8x8 tile bits, 4x4 tiles at (3,3): first 792, stride 32
    pulses1 = 0;
    send_hdr(1, 3, 3, 5, 20);
    send_data(1, 1024, 792, 32, 8, 8, 1'b1);
    q_row1.push_back(20);
    idle(1, 4);
    check("u1 pulses addr(3,3)", pulses1, 64);
    check("u1 row_num", row1, 20);

    idle(0, 4);
    check("u0 data queue drained", q_data0.size(), 0);
    check("u0 latch queue drained", q_row0.size(), 0);
    check("u0 oe queue drained", q_oe0.size(), 0);
    check("u0 error queue drained", q_err0.size(), 0);
    check("u1 data queue drained", q_data1.size(), 0);
    check("u1 latch queue drained", q_row1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
